// File: rtl/mem_req_ctrl.sv
// In-order request front-end for the banked byte memory: FIFO-buffered requests, one response register.
// Optional issue counters (stat_wr_cnt / stat_rd_cnt) when MEM_REQ_CTRL_STATS_EN is defined.
module mem_req_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 10,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_write,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic [AW-1:0] rsp_addr,
   output logic          mem_wen,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
`ifdef MEM_REQ_CTRL_STATS_EN
   ,
   output logic [15:0]   stat_wr_cnt,
   output logic [15:0]   stat_rd_cnt
`endif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   req_t          fifo_q [DEPTH];
   req_t          head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          empty;
   logic          push;
   logic          pop;
   logic          slot_free;
   logic          issue_wr;
   logic          issue_rd;

   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign req_ready = (count < CW'(DEPTH));
   assign push      = req_valid && req_ready;
   assign empty     = (count == '0);
   assign head      = fifo_q[rd_ptr];
   assign slot_free = !rsp_valid || rsp_ready;
   assign issue_wr  = !empty && head.write;
   assign issue_rd  = !empty && !head.write && slot_free;
   assign pop       = issue_wr || issue_rd;

   // Memory port is driven straight from the FIFO head.
   always_comb begin
      mem_wen   = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (!empty) begin
         mem_wen   = head.write;
         mem_addr  = head.addr;
         mem_wdata = head.wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Single response slot; data/addr hold after the consumer drains it.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
      end else if (issue_rd) begin
         rsp_valid <= 1'b1;
         rsp_data  <= mem_rdata;
         rsp_addr  <= head.addr;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef MEM_REQ_CTRL_STATS_EN
   // Saturating issue counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_wr_cnt <= '0;
         stat_rd_cnt <= '0;
      end else begin
         if (issue_wr && (stat_wr_cnt != 16'hFFFF)) stat_wr_cnt <= stat_wr_cnt + 16'd1;
         if (issue_rd && (stat_rd_cnt != 16'hFFFF)) stat_rd_cnt <= stat_rd_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural 1 KiB combinational-read memory attached.
module tb_mem_req_ctrl;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] rsp_addr;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
`ifdef MEM_REQ_CTRL_STATS_EN
   logic [15:0]   stat_wr_cnt;
   logic [15:0]   stat_rd_cnt;
`endif

   int tests = 0;
   int fails = 0;

   mem_req_ctrl #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef MEM_REQ_CTRL_STATS_EN
      ,
      .stat_wr_cnt (stat_wr_cnt),
      .stat_rd_cnt (stat_rd_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write at the clock edge.
   logic          tb_clr;
   logic [DW-1:0] mem [1024];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (tb_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
      end else if (mem_wen) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   // Response log and write-enable pulse counter.
   logic [31:0] rsp_log [64];
   int          rsp_n  = 0;
   int          wen_cnt = 0;
   always @(posedge clk) begin
      if (rsp_valid && rsp_ready && rsp_n < 64) begin
         rsp_log[rsp_n] <= {14'd0, rsp_addr, rsp_data};
         rsp_n <= rsp_n + 1;
      end
      if (mem_wen) wen_cnt <= wen_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Offer one request and hold it until accepted (bounded).
   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int guard;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      guard = 0;
      while (!req_ready && guard < 50) begin
         tick();
         guard++;
      end
      check("send_ready", 32'(req_ready), 32'd1);
      tick();
   endtask

   function automatic logic [31:0] rsp_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
      return {14'd0, a, d};
   endfunction

   int base;
   int w0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tb_clr = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      tick(); tick();
      rst = 1'b0; tb_clr = 1'b0;

      // Reset state
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mem_wen",   32'(mem_wen),   32'd0);
      check("rst_mem_addr",  32'(mem_addr),  32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data",  32'(rsp_data),  32'd0);
      check("rst_rsp_addr",  32'(rsp_addr),  32'd0);

      // Write 0x2A5=0x5C then read it back
      rsp_ready = 1'b1;
      w0 = wen_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h2A5; req_wdata = 8'h5C;
      tick();
      req_write = 1'b0; req_wdata = 8'h00;
      check("t1_wr_wen",   32'(mem_wen),   32'd1);
      check("t1_wr_addr",  32'(mem_addr),  32'h2A5);
      check("t1_wr_wdata", 32'(mem_wdata), 32'h5C);
      tick();
      req_valid = 1'b0;
      check("t1_rd_wen",       32'(mem_wen),   32'd0);
      check("t1_rd_addr",      32'(mem_addr),  32'h2A5);
      check("t1_rd_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      check("t1_rsp_valid",  32'(rsp_valid),  32'd1);
      check("t1_rsp_data",   32'(rsp_data),   32'h5C);
      check("t1_rsp_addr",   32'(rsp_addr),   32'h2A5);
      check("t1_wen_pulses", 32'(wen_cnt - w0), 32'd1);
      tick();
      check("t1_rsp_drain", 32'(rsp_valid), 32'd0);
      check("t1_rsp_hold",  32'(rsp_data),  32'h5C);

      // One write per bank, read all back in order
      base = rsp_n;
      send(1'b1, 10'h011, 8'h11);
      send(1'b1, 10'h111, 8'h22);
      send(1'b1, 10'h211, 8'h33);
      send(1'b1, 10'h311, 8'h44);
      send(1'b0, 10'h011, 8'h00);
      send(1'b0, 10'h111, 8'h00);
      send(1'b0, 10'h211, 8'h00);
      send(1'b0, 10'h311, 8'h00);
      req_valid = 1'b0;
      idle(6);
      check("t2_rsp_count", 32'(rsp_n - base), 32'd4);
      check("t2_rsp0", rsp_log[base + 0], rsp_exp(10'h011, 8'h11));
      check("t2_rsp1", rsp_log[base + 1], rsp_exp(10'h111, 8'h22));
      check("t2_rsp2", rsp_log[base + 2], rsp_exp(10'h211, 8'h33));
      check("t2_rsp3", rsp_log[base + 3], rsp_exp(10'h311, 8'h44));

      // Backpressure: one response held, FIFO full, sixth read waits
      rsp_ready = 1'b0;
      base = rsp_n;
      send(1'b0, 10'h011, 8'h00);
      send(1'b0, 10'h111, 8'h00);
      send(1'b0, 10'h211, 8'h00);
      send(1'b0, 10'h311, 8'h00);
      send(1'b0, 10'h2A5, 8'h00);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h011;
      check("t3_full_ready", 32'(req_ready), 32'd0);
      check("t3_held_valid", 32'(rsp_valid), 32'd1);
      check("t3_held_addr",  32'(rsp_addr),  32'h011);
      check("t3_held_data",  32'(rsp_data),  32'h11);
      idle(2);
      check("t3_still_full", 32'(req_ready), 32'd0);
      check("t3_no_rsp",     32'(rsp_n - base), 32'd0);
      rsp_ready = 1'b1;
      send(1'b0, 10'h011, 8'h00);
      req_valid = 1'b0;
      idle(8);
      check("t3_rsp_count", 32'(rsp_n - base), 32'd6);
      check("t3_rsp0", rsp_log[base + 0], rsp_exp(10'h011, 8'h11));
      check("t3_rsp1", rsp_log[base + 1], rsp_exp(10'h111, 8'h22));
      check("t3_rsp2", rsp_log[base + 2], rsp_exp(10'h211, 8'h33));
      check("t3_rsp3", rsp_log[base + 3], rsp_exp(10'h311, 8'h44));
      check("t3_rsp4", rsp_log[base + 4], rsp_exp(10'h2A5, 8'h5C));
      check("t3_rsp5", rsp_log[base + 5], rsp_exp(10'h011, 8'h11));

      // Top-address write/read back-to-back
      base = rsp_n;
      send(1'b1, 10'h3FF, 8'hA7);
      send(1'b0, 10'h3FF, 8'h00);
      send(1'b1, 10'h3FF, 8'h00);
      send(1'b0, 10'h3FF, 8'h00);
      req_valid = 1'b0;
      idle(6);
      check("t4_rsp_count", 32'(rsp_n - base), 32'd2);
      check("t4_rsp0", rsp_log[base + 0], rsp_exp(10'h3FF, 8'hA7));
      check("t4_rsp1", rsp_log[base + 1], rsp_exp(10'h3FF, 8'h00));

      // Writes queued behind a stalled read are discarded by reset
      rsp_ready = 1'b0;
      send(1'b0, 10'h011, 8'h00);
      send(1'b0, 10'h111, 8'h00);
      w0 = wen_cnt;
      send(1'b1, 10'h050, 8'h99);
      send(1'b1, 10'h150, 8'h98);
      send(1'b1, 10'h250, 8'h97);
      req_valid = 1'b0;
      idle(2);
      check("t5_wen_pre",  32'(wen_cnt - w0), 32'd0);
      check("t5_full_pre", 32'(req_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_req_ready", 32'(req_ready), 32'd1);
      check("t5_mem_wen",   32'(mem_wen),   32'd0);
      idle(4);
      check("t5_wen_post",  32'(wen_cnt - w0), 32'd0);
      check("t5_mem_050",   32'(mem[10'h050]), 32'd0);
      check("t5_mem_250",   32'(mem[10'h250]), 32'd0);
      rsp_ready = 1'b1;

`ifdef MEM_REQ_CTRL_STATS_EN
      send(1'b1, 10'h060, 8'h01);
      send(1'b1, 10'h160, 8'h02);
      send(1'b1, 10'h260, 8'h03);
      send(1'b0, 10'h060, 8'h00);
      send(1'b0, 10'h160, 8'h00);
      req_valid = 1'b0;
      idle(6);
      check("st_wr_cnt", 32'(stat_wr_cnt), 32'd3);
      check("st_rd_cnt", 32'(stat_rd_cnt), 32'd2);
      force dut.stat_wr_cnt = 16'hFFFF;
      tick();
      release dut.stat_wr_cnt;
      send(1'b1, 10'h360, 8'h04);
      req_valid = 1'b0;
      idle(3);
      check("st_wr_sat", 32'(stat_wr_cnt), 32'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
